display_arbiter: RTL

Fixed-priority arbiter that shares the two-digit 7-segment display between up to four value sources (score, countdown, game timer, difficulty level).
- Sources request either by level or by a one-cycle "announce" pulse.
- The arbiter enforces a minimum display hold time and optionally blinks the granted source.
- It sits between the game control logic and two_digit_7seg and drives its 8-bit value input and a blank control.

---
 rtl/display_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/display_arbiter.sv
// display_arbiter: fixed-priority sharing of the two-digit 7-segment display
// between up to four value sources. Bit 0 of req/pulse_req has the highest
// priority. A grant is held for at least HOLD_TICKS cycles unless a
// higher-priority source preempts it. The granted source can optionally blink.
module display_arbiter #(
  parameter int HOLD_TICKS  = 50_000_000,
  parameter int BLINK_TICKS = 25_000_000,
  parameter int CNT_WIDTH   = 27
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [3:0]  pulse_req,
  input  logic [31:0] src_value,
  input  logic [3:0]  blink_en,
  output logic [3:0]  grant,
  output logic        grant_valid,
  output logic [7:0]  display_value,
  output logic        blank,
  output logic        switch_pulse
);

  localparam logic [CNT_WIDTH-1:0] HOLD_LAST  = CNT_WIDTH'(HOLD_TICKS - 1);
  localparam logic [CNT_WIDTH-1:0] BLINK_LAST = CNT_WIDTH'(BLINK_TICKS - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t               state, state_next;
  logic [3:0]           grant_next;
  logic [3:0]           pending, pending_next;
  logic [CNT_WIDTH-1:0] hold_cnt, hold_next;
  logic [CNT_WIDTH-1:0] blink_cnt, blink_next;
  logic                 blank_next;
  logic                 switch_next;
  logic [3:0]           active;
  logic [3:0]           higher;
  logic [3:0]           remaining;
  logic [7:0]           value_sel;

  // Isolate the lowest set bit: the highest-priority source in a mask.
  function automatic logic [3:0] lowest(input logic [3:0] v);
    return v & (~v + 4'd1);
  endfunction

  assign grant_valid = |grant;

  // Byte of src_value belonging to the currently granted source.
  always_comb begin
    value_sel = 8'd0;
    case (grant)
      4'b0001: value_sel = src_value[7:0];
      4'b0010: value_sel = src_value[15:8];
      4'b0100: value_sel = src_value[23:16];
      4'b1000: value_sel = src_value[31:24];
      default: value_sel = 8'd0;
    endcase
  end

  // Next-state logic: arbitration, hold timing, pending announces and blink.
  always_comb begin
    state_next   = state;
    grant_next   = grant;
    hold_next    = hold_cnt;
    blink_next   = blink_cnt;
    blank_next   = blank;
    switch_next  = 1'b0;
    pending_next = pending;
    active       = req | pending | pulse_req;
    // For a one-hot grant, grant-1 masks exactly the higher-priority sources.
    higher       = active & (grant - 4'd1);
    remaining    = active & ~grant;

    case (state)
      IDLE: begin
        blank_next = 1'b1;
        blink_next = '0;
        hold_next  = '0;
        if (|active) begin
          state_next  = GRANT;
          grant_next  = lowest(active);
          switch_next = 1'b1;
          blank_next  = 1'b0;
        end
      end
      GRANT: begin
        if (|higher) begin
          // Preemption ignores the hold; the preempted pending bit survives.
          grant_next  = lowest(higher);
          hold_next   = '0;
          switch_next = 1'b1;
        end else if (|(pulse_req & grant)) begin
          // Re-announce of the shown source restarts its hold silently.
          hold_next = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          pending_next = pending & ~grant;
          if (!(|(req & grant))) begin
            switch_next = 1'b1;
            hold_next   = '0;
            if (|remaining) begin
              grant_next = lowest(remaining);
            end else begin
              state_next = IDLE;
              grant_next = 4'd0;
            end
          end
        end else begin
          hold_next = hold_cnt + 1'b1;
        end

        if (switch_next) begin
          blink_next = '0;
          blank_next = (state_next == IDLE);
        end else if (|(blink_en & grant)) begin
          if (blink_cnt == BLINK_LAST) begin
            blink_next = '0;
            blank_next = ~blank;
          end else begin
            blink_next = blink_cnt + 1'b1;
          end
        end else begin
          blink_next = '0;
          blank_next = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = 4'd0;
        blank_next = 1'b1;
      end
    endcase

    // An announce in the same cycle as a hold completion keeps the bit set.
    pending_next = pending_next | pulse_req;
  end

  // State, counters and registered outputs; reset aborts any hold at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      grant         <= 4'd0;
      pending       <= 4'd0;
      hold_cnt      <= '0;
      blink_cnt     <= '0;
      blank         <= 1'b1;
      switch_pulse  <= 1'b0;
      display_value <= 8'd0;
    end else begin
      state         <= state_next;
      grant         <= grant_next;
      pending       <= pending_next;
      hold_cnt      <= hold_next;
      blink_cnt     <= blink_next;
      blank         <= blank_next;
      switch_pulse  <= switch_next;
      display_value <= value_sel;
    end
  end

endmodule
